// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain
// Purpose  : Pops bytes from the byte FIFO and sends them as 8N1 UART frames
//            (8E1 when UART_TX_PARITY_EN is defined), LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
   parameter int CLK_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       fifo_read_ready,
   input  logic [7:0] fifo_read_data,
   output logic       fifo_read_enable,
   output logic       txd,
   output logic       busy,
   output logic       frame_done
);

   localparam int                 c_cnt_w     = $clog2(CLK_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_cnt_w-1:0] r_baud_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               w_bit_end;
   logic               w_baud_clr;
   logic               w_txd;
   logic               w_rd_en;
   logic               w_busy;
   logic               w_done;

   assign w_bit_end  = (r_baud_cnt == c_baud_last);
   assign w_baud_clr = (r_state == S_IDLE) || (r_state == S_FETCH) || w_bit_end;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_clr ? '0 : r_baud_cnt + 1'b1;
         // Index wraps 7 -> 0 as DATA is left, so it is ready for the next byte.
         if (r_state != S_DATA)
            r_bit_idx <= 3'd0;
         else if (w_bit_end)
            r_bit_idx <= r_bit_idx + 3'd1;
         if (r_state == S_FETCH)
            r_shift <= fifo_read_data;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_txd       = 1'b1;
      w_rd_en     = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            // FIFO head data is registered, so it is only valid one cycle later.
            if (fifo_read_ready)
               w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_rd_en     = 1'b1;
            w_state_nxt = S_START;
         end
         S_START: begin
            w_txd = 1'b0;
            if (w_bit_end)
               w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_txd = r_shift[r_bit_idx];
            if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            w_txd = ^r_shift;
            if (w_bit_end)
               w_state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_bit_end) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign fifo_read_enable = w_rd_en;
   assign txd              = w_txd;
   assign busy             = w_busy;
   assign frame_done       = w_done;

endmodule
`default_nettype wire

// File: doc/uart_tx_drain.md
# uart_tx_drain

Consumer end of the byte FIFO. Pops one byte at a time through the FIFO's read handshake and serializes it as an 8N1 UART frame on `txd`, LSB first, at a fixed clocks-per-bit rate. Sits between the CPU's output FIFO and the board TX pin, so the CPU never stalls on the line rate.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `fifo_read_ready` in 1: FIFO non-empty. Connects to FIFO `read_ready`.
- `fifo_read_data` in 8: FIFO registered head data. Connects to FIFO `read_data`; reflects the head one cycle after the head address settles.
- `fifo_read_enable` out 1: one-cycle pop pulse. Connects to FIFO `read_enable`.
- `txd` out 1: serial line, idle high.
- `busy` out 1: frame in progress (FETCH through STOP).
- `frame_done` out 1: one-cycle pulse in the last cycle of STOP.

## Operation
- States: IDLE, FETCH, START, DATA, (PARITY), STOP.
- Bit counter `bit_idx` is 3 bits, 0..7.
- Baud counter `baud_cnt` is `$clog2(CLK_PER_BIT)` bits. It counts 0..CLK_PER_BIT-1 and is cleared on every state or bit change.
- IDLE:
  - `txd`=1.
  - If `fifo_read_ready`=1, go to FETCH. No pop is issued in IDLE.
  - The one-cycle wait is required: the FIFO's registered `read_data` becomes valid only one edge after `read_ready` rises.
- FETCH (exactly 1 cycle):
  - Latch `fifo_read_data` into the shift register.
  - Assert `fifo_read_enable`=1. This is the only state that ever asserts it, and it is asserted exactly once per byte.
  - Go to START.
- START: `txd`=0 for CLK_PER_BIT cycles, then go to DATA with `bit_idx`=0.
- DATA:
  - `txd`=shift[`bit_idx`] for CLK_PER_BIT cycles per bit.
  - After bit 7, go to PARITY if enabled, else STOP.
- STOP:
  - `txd`=1 for CLK_PER_BIT cycles.
  - `frame_done`=1 on the final cycle.
  - Then go to IDLE.
- `fifo_read_ready` is ignored outside IDLE.
- A FIFO write during a frame does not affect the latched byte.
- The block never pops an empty FIFO. That holds because FETCH is entered only from IDLE with `fifo_read_ready`=1, and this block is the FIFO's sole reader.

## Timing
- Reset values: `txd`=1, `fifo_read_enable`=0, `busy`=0, `frame_done`=0, state=IDLE, all counters 0.
- Reset mid-frame: at the next edge with `reset_n`=0, `txd` goes to 1 and the state goes to IDLE. The popped byte is discarded and is not re-read.
- Latency: `fifo_read_ready` rises in cycle N (IDLE).
  - FETCH is cycle N+1, with `fifo_read_enable`=1.
  - START begins in cycle N+2.
- Frame length: 10·CLK_PER_BIT cycles from START to end of STOP; 11·CLK_PER_BIT with parity.
- Back-to-back bytes: after STOP ends, one IDLE cycle and one FETCH cycle follow. Line-high time between frames is therefore CLK_PER_BIT+2 cycles.
- `busy` is 1 from the FETCH cycle through the last STOP cycle inclusive, and 0 in IDLE.
- All outputs are registered or decoded from registered state. No combinational path runs from `fifo_*` inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state follows DATA. `txd` = XOR of the 8 data bits (even parity) for CLK_PER_BIT cycles, then STOP. Frame is 8E1, 11·CLK_PER_BIT cycles.
  - Undefined: PARITY state and logic are absent. Frame is 8N1, 10·CLK_PER_BIT cycles.

## Test plan
- Single byte, CLK_PER_BIT=4: FIFO holds 0x55.
  - `fifo_read_enable` pulses once, 1 cycle after `read_ready`.
  - `txd` shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `frame_done` pulses at cycle 40 of the frame; `busy` then falls.
- Back-to-back, CLK_PER_BIT=4: push 0xA5 and 0x3C.
  - Two frames, LSB first, with 6 high cycles between the end of frame 1's start-to-stop window and the next start bit (stop time included).
  - Exactly two pops.
- Empty FIFO: `read_ready`=0 for 1000 cycles → `txd`=1, `busy`=0, and no pop.
- Reset mid-DATA: assert `reset_n`=0 during bit 3 of 0xFF.
  - Next edge gives `txd`=1 and `busy`=0.
  - After release with the FIFO empty, no frame and no pop.
- Parity (macro defined), CLK_PER_BIT=2: send 0x07 → parity bit 1; send 0x03 → parity bit 0. Each frame is 22 cycles.
- Minimum rate, CLK_PER_BIT=2: send 0x80 → every bit is held exactly 2 cycles, and bit 7 = 1 precedes the stop bit.
